pg_port_quiesce_ctrl: RTL and testbench
=======================================

// Module: pg_port_quiesce_ctrl
// PURPOSE
// - Per-port reset sequencer for the port gasket. Generalises the fixed two-flop port-reset pipeline to N ports x M TX channels.
// - On a port reset request, it lets in-flight AFU->FIM TX packets finish at tlast and blocks new SOPs. It then asserts the port reset, holds it, and releases it.
// - Sits between FME port-control and the PF/VF MUX AFU-side ports. A drain timeout protects against a hung AFU.
// PARAMETERS
// - NUM_PORTS      4     number of AFU ports (links x ports, linearised)
// - NUM_TX_CH      2     TX streams observed per port (A, B)
// - DRAIN_TIMEOUT  1024  max DRAIN cycles before forced reset; 0 = no timeout
// - RST_HOLD       16    min cycles port_rst_n held low (>=1)
// - SETTLE         4     cycles after reset release before unblocking TX (>=1)
// PORTS
// - clk             in   1                  gasket clock
// - rst             in   1                  async, active-high global reset
// - port_rst_req    in   NUM_PORTS          level; 1 = FME requests port reset
// - tx_tvalid       in   NUM_PORTS*NUM_TX_CH  AFU TX tvalid, index c = port*NUM_TX_CH+ch
// - tx_tready       in   NUM_PORTS*NUM_TX_CH  FIM-side tready for same stream
// - tx_tlast        in   NUM_PORTS*NUM_TX_CH  AFU TX tlast
// - tx_block        out  NUM_PORTS*NUM_TX_CH  1 = gasket must force tvalid/tready low on this stream
// - port_rst_n      out  NUM_PORTS          registered active-low reset to the AFU port
// - port_rst_ack    out  NUM_PORTS          1 = port is quiesced and held in reset
// - drain_timeout   out  NUM_PORTS          sticky; drain aborted by timeout
// BEHAVIOUR
// - Per-channel in_pkt flag:
//   - set on tvalid&tready&!tlast; cleared on tvalid&tready&tlast.
//   - Single-beat packets leave it 0. Cleared when the owning port enters RESET.
// - Per-port FSM, one-hot encoded: RUN, DRAIN, RESET, SETTLE. All outputs are registered.
// - Reset (rst=1) values: state=RESET, hold cnt=0, port_rst_n=0, tx_block=all 1, ack=0, drain_timeout=0, in_pkt=0.
// - RUN:
//   - port_rst_n=1, tx_block=0.
//   - port_rst_req=1 -> DRAIN next cycle; drain counter cleared.
// - DRAIN:
//   - tx_block[c] = !in_pkt[c]: an idle channel is blocked immediately; a mid-packet channel stays open until its tlast beat.
//   - Block takes effect the cycle after that beat, and the flag is registered, so no new SOP is accepted after tlast.
//   - Exit to RESET when all channels of the port have in_pkt=0, evaluated on registered flags, so exit occurs the cycle after the last tlast.
//   - Timeout: counter increments each DRAIN cycle. At count == DRAIN_TIMEOUT-1 (when DRAIN_TIMEOUT!=0): go to RESET, set drain_timeout, block all channels.
//   - A req drop during DRAIN does NOT abort; the sequence completes.
// - RESET:
//   - port_rst_n=0, tx_block=1, hold counter increments (saturating).
//   - port_rst_ack=1 once hold count >= RST_HOLD.
//   - Leave to SETTLE when hold count >= RST_HOLD and port_rst_req=0.
// - SETTLE:
//   - port_rst_n=1, tx_block=1, ack=0, settle counter runs.
//   - After SETTLE cycles -> RUN.
//   - port_rst_req=1 during SETTLE -> RESET (hold counter cleared), no drain needed.
// - drain_timeout is cleared only by rst, or on entry to DRAIN of a new request.
// - Ports are fully independent; simultaneous requests on all ports have no interaction.
// - Latency: req rise -> port_rst_n low is >= 2 cycles (RUN->DRAIN->RESET), plus drain time.
// - Counter widths: $clog2(max(param)+1); no wrap (saturate).
// - rst asserted mid-sequence: immediate return to the reset values above, regardless of state.
// TESTING
// - Global reset, req=0: port_rst_n=0 for 16 cycles after rst falls, then 1; tx_block=1 for 4 more cycles, then 0.
// - Port1 idle, req pulse of 1 cycle -> DRAIN 1 cycle, RESET 16 cycles (ack high at 16th), SETTLE 4, RUN; ports 0/2/3 untouched.
// - Port0 ch0 mid 8-beat packet at beat 3 when req rises -> tx_block[0] stays 0 until beat 8 tlast. block=1 next cycle, then port_rst_n=0 the cycle after. ch1 is blocked from the first DRAIN cycle.
// - Port2 ch1 stalled mid-packet (tready=0 forever), DRAIN_TIMEOUT=1024 -> RESET entered exactly 1024 cycles after DRAIN entry; drain_timeout[2]=1 sticky.
// - req held high 100 cycles -> port_rst_n low for 100+ cycles, ack=1 from hold cycle 16. Re-assert req in SETTLE cycle 2 -> back to RESET, no DRAIN.
// - rst asserted while port3 is in DRAIN -> same cycle: port_rst_n=0, tx_block=1, ack=0, drain_timeout=0, in_pkt cleared.

Source files
------------

// File: rtl/pg_port_quiesce_ctrl.sv
// Per-port reset sequencer: lets in-flight AFU TX packets finish at tlast,
// then asserts, holds and releases the port reset before reopening TX.
module pg_port_quiesce_ctrl #(
   parameter int unsigned NUM_PORTS     = 4,
   parameter int unsigned NUM_TX_CH     = 2,
   parameter int unsigned DRAIN_TIMEOUT = 1024,
   parameter int unsigned RST_HOLD      = 16,
   parameter int unsigned SETTLE        = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_PORTS-1:0]           port_rst_req,
   input  logic [NUM_PORTS*NUM_TX_CH-1:0] tx_tvalid,
   input  logic [NUM_PORTS*NUM_TX_CH-1:0] tx_tready,
   input  logic [NUM_PORTS*NUM_TX_CH-1:0] tx_tlast,
   output logic [NUM_PORTS*NUM_TX_CH-1:0] tx_block,
   output logic [NUM_PORTS-1:0]           port_rst_n,
   output logic [NUM_PORTS-1:0]           port_rst_ack,
   output logic [NUM_PORTS-1:0]           drain_timeout
);

   localparam int unsigned DRAIN_MAX = (DRAIN_TIMEOUT > 0) ? DRAIN_TIMEOUT : 1;
   localparam int unsigned DRAIN_W   = $clog2(DRAIN_MAX + 1);
   localparam int unsigned HOLD_W    = $clog2(RST_HOLD + 1);
   localparam int unsigned SET_W     = $clog2(SETTLE + 1);
   localparam bit          TIMEOUT_EN = (DRAIN_TIMEOUT != 0);

   localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_MAX - 1);
   localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(RST_HOLD - 1);
   localparam logic [HOLD_W-1:0]  HOLD_MAX   = HOLD_W'(RST_HOLD);
   localparam logic [SET_W-1:0]   SET_LAST   = SET_W'(SETTLE - 1);
   localparam logic [SET_W-1:0]   SET_MAX    = SET_W'(SETTLE);

   typedef enum logic [3:0] {
      ST_RUN    = 4'b0001,
      ST_DRAIN  = 4'b0010,
      ST_RESET  = 4'b0100,
      ST_SETTLE = 4'b1000
   } state_e;

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
      localparam int unsigned LO = p * NUM_TX_CH;

      state_e               state_q, state_d;
      logic [HOLD_W-1:0]    hold_q, hold_d;
      logic [DRAIN_W-1:0]   drain_q, drain_d;
      logic [SET_W-1:0]     settle_q, settle_d;
      logic [NUM_TX_CH-1:0] in_pkt_q, in_pkt_d;
      logic [NUM_TX_CH-1:0] blk_q, blk_d;
      logic [NUM_TX_CH-1:0] hs;
      logic                 rst_n_q, rst_n_d;
      logic                 ack_q, ack_d;
      logic                 to_q, to_d;

      assign hs = tx_tvalid[LO +: NUM_TX_CH] & tx_tready[LO +: NUM_TX_CH];

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            state_q  <= ST_RESET;
            hold_q   <= '0;
            drain_q  <= '0;
            settle_q <= '0;
            in_pkt_q <= '0;
            blk_q    <= '1;
            rst_n_q  <= 1'b0;
            ack_q    <= 1'b0;
            to_q     <= 1'b0;
         end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            drain_q  <= drain_d;
            settle_q <= settle_d;
            in_pkt_q <= in_pkt_d;
            blk_q    <= blk_d;
            rst_n_q  <= rst_n_d;
            ack_q    <= ack_d;
            to_q     <= to_d;
         end
      end

      always_comb begin
         state_d  = state_q;
         hold_d   = '0;
         drain_d  = drain_q;
         settle_d = '0;
         to_d     = to_q;

         unique case (state_q)
            ST_RUN: begin
               if (port_rst_req[p]) begin
                  state_d = ST_DRAIN;
                  drain_d = '0;
                  to_d    = 1'b0;
               end
            end
            ST_DRAIN: begin
               if (drain_q != '1) drain_d = drain_q + DRAIN_W'(1);
               // Exit uses registered flags, so the last tlast beat is already gone.
               if (in_pkt_q == '0) begin
                  state_d = ST_RESET;
               end else if (TIMEOUT_EN && (drain_q == DRAIN_LAST)) begin
                  state_d = ST_RESET;
                  to_d    = 1'b1;
               end
            end
            ST_RESET: begin
               hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + HOLD_W'(1);
               if ((hold_q >= HOLD_LAST) && !port_rst_req[p]) begin
                  state_d = ST_SETTLE;
                  hold_d  = '0;
               end
            end
            ST_SETTLE: begin
               settle_d = (settle_q == SET_MAX) ? settle_q : settle_q + SET_W'(1);
               if (port_rst_req[p]) begin
                  state_d  = ST_RESET;
                  settle_d = '0;
               end else if (settle_q >= SET_LAST) begin
                  state_d  = ST_RUN;
                  settle_d = '0;
               end
            end
            default: state_d = ST_RESET;
         endcase

         in_pkt_d = (hs & ~tx_tlast[LO +: NUM_TX_CH]) | (in_pkt_q & ~hs);
         if (state_d == ST_RESET) in_pkt_d = '0;

         // Outputs are registered from the next-state view so they align with the state.
         rst_n_d = (state_d != ST_RESET);
         ack_d   = (state_d == ST_RESET) && (hold_d >= HOLD_LAST);
         case (state_d)
            ST_RUN:   blk_d = '0;
            ST_DRAIN: blk_d = ~in_pkt_d;
            default:  blk_d = '1;
         endcase
      end

      assign tx_block[LO +: NUM_TX_CH] = blk_q;
      assign port_rst_n[p]             = rst_n_q;
      assign port_rst_ack[p]           = ack_q;
      assign drain_timeout[p]          = to_q;
   end

endmodule

// File: tb/tb_pg_port_quiesce_ctrl.sv
// Bench for pg_port_quiesce_ctrl: vector table, directed corner sequences and
// random traffic against a phase/age reference model.
module tb_pg_port_quiesce_ctrl;

   localparam int NP   = 4;
   localparam int NC   = 2;
   localparam int NCH  = NP * NC;
   localparam int TMO  = 1024;
   localparam int HOLD = 16;
   localparam int SET  = 4;

   localparam int P_RUN    = 0;
   localparam int P_DRAIN  = 1;
   localparam int P_RESET  = 2;
   localparam int P_SETTLE = 3;

   typedef struct {
      logic [NP-1:0]  req;
      int             n;
      logic [NP-1:0]  rst_n;
      logic [NCH-1:0] blk;
      logic [NP-1:0]  ack;
   } vec_t;

   logic           clk = 1'b0;
   logic           rst;
   logic [NP-1:0]  port_rst_req;
   logic [NCH-1:0] tx_tvalid, tx_tready, tx_tlast, tx_block;
   logic [NP-1:0]  port_rst_n, port_rst_ack, drain_timeout;

   pg_port_quiesce_ctrl #(
      .NUM_PORTS    (NP),
      .NUM_TX_CH    (NC),
      .DRAIN_TIMEOUT(TMO),
      .RST_HOLD     (HOLD),
      .SETTLE       (SET)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .port_rst_req (port_rst_req),
      .tx_tvalid    (tx_tvalid),
      .tx_tready    (tx_tready),
      .tx_tlast     (tx_tlast),
      .tx_block     (tx_block),
      .port_rst_n   (port_rst_n),
      .port_rst_ack (port_rst_ack),
      .drain_timeout(drain_timeout)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference model: phase per port plus 1-based age within that phase.
   int m_phase [NP];
   int m_age   [NP];
   bit m_tmo   [NP];
   bit m_pkt   [NCH];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int p = 0; p < NP; p++) begin
         m_phase[p] = P_RESET;
         m_age[p]   = 1;
         m_tmo[p]   = 1'b0;
      end
      for (int c = 0; c < NCH; c++) m_pkt[c] = 1'b0;
   endtask

   task automatic model_step();
      for (int p = 0; p < NP; p++) begin
         bit idle;
         int nxt;
         idle = 1'b1;
         for (int ch = 0; ch < NC; ch++) if (m_pkt[p*NC+ch]) idle = 1'b0;
         for (int ch = 0; ch < NC; ch++) begin
            int c;
            c = p*NC + ch;
            if (tx_tvalid[c] && tx_tready[c]) m_pkt[c] = !tx_tlast[c];
         end
         nxt = m_phase[p];
         case (m_phase[p])
            P_RUN: if (port_rst_req[p]) begin
               nxt = P_DRAIN;
               m_tmo[p] = 1'b0;
            end
            P_DRAIN: begin
               if (idle) nxt = P_RESET;
               else if (m_age[p] == TMO) begin
                  nxt = P_RESET;
                  m_tmo[p] = 1'b1;
               end
            end
            P_RESET: if (m_age[p] >= HOLD && !port_rst_req[p]) nxt = P_SETTLE;
            default: begin
               if (port_rst_req[p]) nxt = P_RESET;
               else if (m_age[p] >= SET) nxt = P_RUN;
            end
         endcase
         m_age[p]   = (nxt == m_phase[p]) ? m_age[p] + 1 : 1;
         m_phase[p] = nxt;
         if (nxt == P_RESET) for (int ch = 0; ch < NC; ch++) m_pkt[p*NC+ch] = 1'b0;
      end
   endtask

   task automatic check_model();
      logic [NP-1:0]  e_rst_n, e_ack, e_tmo;
      logic [NCH-1:0] e_blk;
      for (int p = 0; p < NP; p++) begin
         e_rst_n[p] = (m_phase[p] != P_RESET);
         e_ack[p]   = (m_phase[p] == P_RESET) && (m_age[p] >= HOLD);
         e_tmo[p]   = m_tmo[p];
         for (int ch = 0; ch < NC; ch++) begin
            int c;
            c = p*NC + ch;
            if (m_phase[p] == P_RUN)        e_blk[c] = 1'b0;
            else if (m_phase[p] == P_DRAIN) e_blk[c] = !m_pkt[c];
            else                            e_blk[c] = 1'b1;
         end
      end
      chk("model_rst_n", 32'(port_rst_n), 32'(e_rst_n));
      chk("model_block", 32'(tx_block), 32'(e_blk));
      chk("model_ack", 32'(port_rst_ack), 32'(e_ack));
      chk("model_timeout", 32'(drain_timeout), 32'(e_tmo));
   endtask

   task automatic tick();
      if (rst) model_reset();
      else     model_step();
      @(posedge clk);
      @(negedge clk);
      check_model();
   endtask

   task automatic wait_run(input int p, input string name);
      logic [NC-1:0] s;
      int n;
      n = 0;
      while (n < 100 && !(port_rst_n[p] && tx_block[p*NC +: NC] == '0)) begin
         tick();
         n++;
      end
      s = tx_block[p*NC +: NC];
      chk(name, 32'(s), 32'(0));
   endtask

   initial begin
      vec_t vt [12];
      int   n;

      vt[0]  = '{4'h0, 14, 4'h0, 8'hFF, 4'h0};
      vt[1]  = '{4'h0,  1, 4'h0, 8'hFF, 4'hF};
      vt[2]  = '{4'h0,  1, 4'hF, 8'hFF, 4'h0};
      vt[3]  = '{4'h0,  3, 4'hF, 8'hFF, 4'h0};
      vt[4]  = '{4'h0,  1, 4'hF, 8'h00, 4'h0};
      vt[5]  = '{4'h2,  1, 4'hF, 8'h0C, 4'h0};
      vt[6]  = '{4'h0,  1, 4'hD, 8'h0C, 4'h0};
      vt[7]  = '{4'h0, 14, 4'hD, 8'h0C, 4'h0};
      vt[8]  = '{4'h0,  1, 4'hD, 8'h0C, 4'h2};
      vt[9]  = '{4'h0,  1, 4'hF, 8'h0C, 4'h0};
      vt[10] = '{4'h0,  3, 4'hF, 8'h0C, 4'h0};
      vt[11] = '{4'h0,  1, 4'hF, 8'h00, 4'h0};

      rst = 1'b1;
      port_rst_req = '0;
      tx_tvalid = '0;
      tx_tready = '0;
      tx_tlast  = '0;
      model_reset();
      repeat (3) @(negedge clk);
      chk("rst_rst_n", 32'(port_rst_n), 32'(0));
      chk("rst_block", 32'(tx_block), 32'(8'hFF));
      chk("rst_ack", 32'(port_rst_ack), 32'(0));
      chk("rst_timeout", 32'(drain_timeout), 32'(0));
      rst = 1'b0;
      #1 check_model();

      // Global reset release sequence, then a one-cycle request on idle port 1.
      for (int i = 0; i < 12; i++) begin
         port_rst_req = vt[i].req;
         for (int k = 0; k < vt[i].n; k++) tick();
         chk($sformatf("vec%0d_rst_n", i), 32'(port_rst_n), 32'(vt[i].rst_n));
         chk($sformatf("vec%0d_block", i), 32'(tx_block), 32'(vt[i].blk));
         chk($sformatf("vec%0d_ack", i), 32'(port_rst_ack), 32'(vt[i].ack));
      end
      port_rst_req = '0;

      // Port 0 ch0 8-beat packet, request rises with beat 3.
      for (int b = 1; b <= 8; b++) begin
         tx_tvalid[0] = 1'b1;
         tx_tready[0] = 1'b1;
         tx_tlast[0]  = (b == 8);
         if (b == 3) port_rst_req[0] = 1'b1;
         tick();
         if (b >= 3 && b < 8) begin
            chk($sformatf("p0_beat%0d_ch0_open", b), 32'(tx_block[0]), 32'(0));
            chk($sformatf("p0_beat%0d_ch1_blk", b), 32'(tx_block[1]), 32'(1));
            chk($sformatf("p0_beat%0d_rst_n", b), 32'(port_rst_n[0]), 32'(1));
         end
      end
      chk("p0_tlast_blk", 32'(tx_block[0]), 32'(1));
      chk("p0_tlast_rst_n", 32'(port_rst_n[0]), 32'(1));
      tx_tvalid = '0;
      tx_tready = '0;
      tx_tlast  = '0;
      port_rst_req[0] = 1'b0;
      tick();
      chk("p0_reset_after_drain", 32'(port_rst_n[0]), 32'(0));
      wait_run(0, "p0_back_to_run");

      // Port 1: request held 100 cycles, then re-request in SETTLE cycle 2.
      port_rst_req[1] = 1'b1;
      for (int t = 1; t <= 100; t++) begin
         tick();
         if (t == 1)  chk("p1_drain_rst_n", 32'(port_rst_n[1]), 32'(1));
         if (t == 2)  chk("p1_reset_rst_n", 32'(port_rst_n[1]), 32'(0));
         if (t == 16) chk("p1_ack_hold15", 32'(port_rst_ack[1]), 32'(0));
         if (t == 17) chk("p1_ack_hold16", 32'(port_rst_ack[1]), 32'(1));
      end
      chk("p1_still_reset", 32'(port_rst_n[1]), 32'(0));
      chk("p1_still_ack", 32'(port_rst_ack[1]), 32'(1));
      port_rst_req[1] = 1'b0;
      tick();
      chk("p1_settle_rst_n", 32'(port_rst_n[1]), 32'(1));
      chk("p1_settle_ack", 32'(port_rst_ack[1]), 32'(0));
      tick();
      port_rst_req[1] = 1'b1;
      tick();
      chk("p1_rereq_rst_n", 32'(port_rst_n[1]), 32'(0));
      chk("p1_rereq_block", 32'(tx_block[3:2]), 32'(3));
      chk("p1_rereq_ack", 32'(port_rst_ack[1]), 32'(0));
      port_rst_req[1] = 1'b0;
      wait_run(1, "p1_back_to_run");

      // Port 2 ch1 (stream 5) stalled mid-packet: drain must time out.
      tx_tvalid[5] = 1'b1;
      tx_tready[5] = 1'b1;
      tick();
      tx_tready[5] = 1'b0;
      port_rst_req[2] = 1'b1;
      tick();
      chk("p2_drain_rst_n", 32'(port_rst_n[2]), 32'(1));
      chk("p2_drain_ch1_open", 32'(tx_block[5]), 32'(0));
      chk("p2_drain_ch0_blk", 32'(tx_block[4]), 32'(1));
      port_rst_req[2] = 1'b0;
      n = 0;
      while (n < 1100 && port_rst_n[2]) begin
         tick();
         n++;
      end
      chk("p2_timeout_cycles", 32'(n), 32'(1024));
      chk("p2_timeout_flag", 32'(drain_timeout), 32'(4'h4));
      tx_tvalid = '0;
      wait_run(2, "p2_back_to_run");
      chk("p2_timeout_sticky", 32'(drain_timeout[2]), 32'(1));

      // Port 3 mid-packet in DRAIN when global reset hits.
      tx_tvalid[6] = 1'b1;
      tx_tready[6] = 1'b1;
      tick();
      tx_tvalid = '0;
      tx_tready = '0;
      port_rst_req[3] = 1'b1;
      repeat (3) tick();
      chk("p3_in_drain", 32'(port_rst_n[3]), 32'(1));
      chk("p3_ch0_open", 32'(tx_block[6]), 32'(0));
      port_rst_req = '0;
      #2 rst = 1'b1;
      #1;
      chk("midrst_rst_n", 32'(port_rst_n), 32'(0));
      chk("midrst_block", 32'(tx_block), 32'(8'hFF));
      chk("midrst_ack", 32'(port_rst_ack), 32'(0));
      chk("midrst_timeout", 32'(drain_timeout), 32'(0));
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (22) tick();
      port_rst_req[3] = 1'b1;
      tick();
      port_rst_req[3] = 1'b0;
      tick();
      chk("p3_inpkt_cleared", 32'(port_rst_n[3]), 32'(0));
      wait_run(3, "p3_back_to_run");

      // Fresh timeout on port 2, then a new request clears the flag.
      tx_tvalid[5] = 1'b1;
      tx_tready[5] = 1'b1;
      tick();
      tx_tready[5] = 1'b0;
      port_rst_req[2] = 1'b1;
      tick();
      port_rst_req[2] = 1'b0;
      n = 0;
      while (n < 1100 && !drain_timeout[2]) begin
         tick();
         n++;
      end
      chk("p2_second_timeout", 32'(drain_timeout[2]), 32'(1));
      tx_tvalid = '0;
      tx_tready = '0;
      wait_run(2, "p2_second_run");
      port_rst_req[2] = 1'b1;
      tick();
      chk("p2_timeout_cleared", 32'(drain_timeout[2]), 32'(0));
      port_rst_req[2] = 1'b0;
      wait_run(2, "p2_third_run");

      // Random traffic and requests on all ports.
      for (int t = 0; t < 3000; t++) begin
         for (int p = 0; p < NP; p++)
            if ($urandom_range(0, 39) == 0) port_rst_req[p] = ~port_rst_req[p];
         tx_tvalid = NCH'($urandom);
         tx_tready = NCH'($urandom | $urandom);
         tx_tlast  = NCH'($urandom & $urandom);
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
